mb_alu_seq: RTL and testbench

Multi-byte operation sequencer for the shared combinational W-bit ALU. It accepts an NB*W-bit operation on a start/ready handshake and latches the operands. It then drives the ALU one byte lane per cycle, chaining the shift/carry bit between lanes, and assembles the result and flags. It sits between the control unit and the ALU, so wide arithmetic and shifts can be done without a wider datapath.

---
 rtl/mb_alu_seq_pkg.sv | 49 ++++
 rtl/mb_lane_mux.sv | 18 +
 rtl/mb_alu_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_mb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer.
//   op_mne     : opcode set of the shared W-bit combinational ALU
//   mb_op_t    : wide operations accepted by mb_alu_seq
//   mb_state_t : sequencer FSM states
// Optional feature macro: MB_ALU_SEQ_CMP_EN adds MB_CMP (subtract, flags only).
package mb_alu_seq_pkg;

    typedef enum logic [2:0] {
        CLR = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        LSH = 3'd6,
        RSH = 3'd7
    } op_mne;

    typedef enum logic [2:0] {
        MB_ADD = 3'd0,
        MB_SUB = 3'd1,
        MB_LSH = 3'd2,
        MB_RSH = 3'd3,
        MB_AND = 3'd4,
        MB_OR  = 3'd5,
        MB_XOR = 3'd6
`ifdef MB_ALU_SEQ_CMP_EN
        ,MB_CMP = 3'd7
`endif
    } mb_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mb_state_t;

    // Ops whose final lane SC bit is reported on CarryOut; everything else reports 0.
    function automatic logic op_has_carry(input mb_op_t op);
        case (op)
            MB_ADD, MB_SUB, MB_LSH, MB_RSH: return 1'b1;
`ifdef MB_ALU_SEQ_CMP_EN
            MB_CMP:                         return 1'b1;
`endif
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mb_lane_mux.sv
// Lane selector: returns lane sel (W bits) of a packed NB*W vector, lane 0 = LSBs.
//   vec  : packed NB*W input vector
//   sel  : lane index, 0..NB-1
//   lane : selected W-bit lane
module mb_lane_mux #(
    parameter int unsigned W  = 8,
    parameter int unsigned NB = 2
) (
    input  logic [NB*W-1:0]         vec,
    input  logic [$clog2(NB)-1:0]   sel,
    output logic [W-1:0]            lane
);

    always_comb begin
        lane = vec[sel*W +: W];
    end

endmodule

// File: rtl/mb_alu_seq.sv
// Multi-byte operation sequencer for a shared W-bit combinational ALU.
// Latches an NB*W-bit operation on Start/Ready, then drives the ALU one lane per
// cycle, chaining the shift/carry bit between lanes, and assembles Result/flags.
// Ports:
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   Start, Op, OpA, OpB,    : request (sampled only while Ready=1)
//   ShiftIn                 : fill bit for shifts
//   Ready, Done             : idle indicator, one-cycle completion pulse
//   Result, CarryOut,       : assembled result and flags (held until next op)
//   ZeroOut
//   AluA, AluB, AluOp,      : drive to the external ALU
//   AluSCin
//   AluOut, AluSCout        : response from the external ALU
// Optional feature macro: MB_ALU_SEQ_CMP_EN (adds MB_CMP: flags only, Result kept).
module mb_alu_seq
    import mb_alu_seq_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned NB = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  mb_op_t          Op,
    input  logic [NB*W-1:0] OpA,
    input  logic [NB*W-1:0] OpB,
    input  logic            ShiftIn,
    output logic            Ready,
    output logic            Done,
    output logic [NB*W-1:0] Result,
    output logic            CarryOut,
    output logic            ZeroOut,
    output logic [W-1:0]    AluA,
    output logic [W-1:0]    AluB,
    output op_mne           AluOp,
    output logic            AluSCin,
    input  logic [W-1:0]    AluOut,
    input  logic            AluSCout
);

    localparam int unsigned CntW = $clog2(NB);
    localparam logic [CntW-1:0] LastLane = CntW'(NB - 1);

    mb_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    mb_op_t          op_q, op_d;
    logic [NB*W-1:0] a_q, a_d;
    logic [NB*W-1:0] b_q, b_d;
    logic            shin_q, shin_d;
    logic            carry_q, carry_d;
    logic [NB*W-1:0] result_q, result_d;
    logic            carry_out_q, carry_out_d;
    logic            zero_q, zero_d;
    // Running "all lanes so far were zero"; lets MB_CMP report ZeroOut without touching Result.
    logic            zacc_q, zacc_d;

    logic [CntW-1:0] lane_idx;
    logic [W-1:0]    a_lane;
    logic [W-1:0]    b_lane;
    logic            first_lane;
    logic            write_result;

    // MB_RSH walks MSB lane first so the shifted-out bit travels downward.
    always_comb begin
        lane_idx   = (op_q == MB_RSH) ? (LastLane - cnt_q) : cnt_q;
        first_lane = (cnt_q == '0);
    end

    mb_lane_mux #(
        .W  (W),
        .NB (NB)
    ) u_mux_a (
        .vec  (a_q),
        .sel  (lane_idx),
        .lane (a_lane)
    );

    mb_lane_mux #(
        .W  (W),
        .NB (NB)
    ) u_mux_b (
        .vec  (b_q),
        .sel  (lane_idx),
        .lane (b_lane)
    );

    // ALU drive, purely from registered state.
    always_comb begin
        AluOp   = CLR;
        AluA    = '0;
        AluB    = '0;
        AluSCin = 1'b0;
        if (state_q == RUN) begin
            AluA = a_lane;
            case (op_q)
                MB_ADD: begin
                    AluOp   = ADD;
                    AluB    = b_lane;
                    AluSCin = first_lane ? 1'b0 : carry_q;
                end
`ifdef MB_ALU_SEQ_CMP_EN
                MB_SUB, MB_CMP: begin
`else
                MB_SUB: begin
`endif
                    // A + ~B + 1: the ALU SUB opcode has no carry-in, so it cannot chain.
                    AluOp   = ADD;
                    AluB    = ~b_lane;
                    AluSCin = first_lane ? 1'b1 : carry_q;
                end
                MB_LSH: begin
                    AluOp   = LSH;
                    AluSCin = first_lane ? shin_q : carry_q;
                end
                MB_RSH: begin
                    AluOp   = RSH;
                    AluSCin = first_lane ? shin_q : carry_q;
                end
                MB_AND: begin
                    AluOp = AND;
                    AluB  = b_lane;
                end
                MB_OR: begin
                    AluOp = OR;
                    AluB  = b_lane;
                end
                MB_XOR: begin
                    AluOp = XOR;
                    AluB  = b_lane;
                end
                default: begin
                    // Unknown encoding: AND with zero forces a zero result.
                    AluOp = AND;
                    AluB  = '0;
                end
            endcase
        end
    end

`ifdef MB_ALU_SEQ_CMP_EN
    assign write_result = (op_q != MB_CMP);
`else
    assign write_result = 1'b1;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        shin_d      = shin_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        zacc_d      = zacc_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    a_d     = OpA;
                    b_d     = OpB;
                    shin_d  = ShiftIn;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    zacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = AluSCout;
                zacc_d  = zacc_q & (AluOut == '0);
                if (write_result) begin
                    result_d[lane_idx*W +: W] = AluOut;
                end
                if (cnt_q == LastLane) begin
                    carry_out_d = op_has_carry(op_q) ? AluSCout : 1'b0;
                    zero_d      = zacc_q & (AluOut == '0);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= MB_ADD;
            a_q         <= '0;
            b_q         <= '0;
            shin_q      <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
            zacc_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shin_q      <= shin_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
            zacc_q      <= zacc_d;
        end
    end

    assign Ready    = (state_q == IDLE);
    assign Done     = (state_q == DONE);
    assign Result   = result_q;
    assign CarryOut = carry_out_q;
    assign ZeroOut  = zero_q;

endmodule

// File: tb/tb_mb_alu_seq.sv
// Bench for mb_alu_seq (W=8, NB=2) with a behavioural model of the shared ALU.
// Expected completions are queued at issue time; a monitor pops one on every Done.
module tb_mb_alu_seq;
    import mb_alu_seq_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned NB = 2;
    localparam int unsigned DW = NB * W;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    mb_op_t        Op = MB_ADD;
    logic [DW-1:0] OpA = '0;
    logic [DW-1:0] OpB = '0;
    logic          ShiftIn = 1'b0;
    logic          Ready;
    logic          Done;
    logic [DW-1:0] Result;
    logic          CarryOut;
    logic          ZeroOut;
    logic [W-1:0]  AluA;
    logic [W-1:0]  AluB;
    op_mne         AluOp;
    logic          AluSCin;
    logic [W-1:0]  AluOut;
    logic          AluSCout;

    mb_alu_seq #(
        .W  (W),
        .NB (NB)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Op       (Op),
        .OpA      (OpA),
        .OpB      (OpB),
        .ShiftIn  (ShiftIn),
        .Ready    (Ready),
        .Done     (Done),
        .Result   (Result),
        .CarryOut (CarryOut),
        .ZeroOut  (ZeroOut),
        .AluA     (AluA),
        .AluB     (AluB),
        .AluOp    (AluOp),
        .AluSCin  (AluSCin),
        .AluOut   (AluOut),
        .AluSCout (AluSCout)
    );

    always #5 Clk = ~Clk;

    // Shared combinational ALU.
    logic [W:0] sum9;
    always_comb begin
        sum9     = '0;
        AluOut   = '0;
        AluSCout = 1'b0;
        case (AluOp)
            ADD: begin
                sum9     = {1'b0, AluA} + {1'b0, AluB} + {{W{1'b0}}, AluSCin};
                AluOut   = sum9[W-1:0];
                AluSCout = sum9[W];
            end
            SUB: AluOut = AluA - AluB;
            AND: AluOut = AluA & AluB;
            OR:  AluOut = AluA | AluB;
            XOR: AluOut = AluA ^ AluB;
            LSH: begin
                AluOut   = {AluA[W-2:0], AluSCin};
                AluSCout = AluA[W-1];
            end
            RSH: begin
                AluOut   = {AluSCin, AluA[W-1:1]};
                AluSCout = AluA[0];
            end
            default: AluOut = '0;
        endcase
    end

    typedef struct {
        logic [DW-1:0] res;
        logic          c;
        logic          z;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_exp    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: got Done=1, want no pulse");
            end else begin
                cur = sb.pop_front();
                check({cur.name, "_result"}, 32'(Result), 32'(cur.res));
                check({cur.name, "_carry"}, 32'(CarryOut), 32'(cur.c));
                check({cur.name, "_zero"}, 32'(ZeroOut), 32'(cur.z));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (Ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (Ready !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_timeout: got Ready=%b after 20 cycles, want 1", nm, Ready);
        end
    endtask

    task automatic push(input logic [DW-1:0] res, input logic c, input logic z,
                        input string nm);
        exp_t e;
        e.res  = res;
        e.c    = c;
        e.z    = z;
        e.name = nm;
        sb.push_back(e);
        n_exp++;
    endtask

    // Returns one cycle after the accepting edge (first RUN cycle).
    task automatic start_op(input mb_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sh, input string nm);
        wait_ready(nm);
        Op      = op;
        OpA     = a;
        OpB     = b;
        ShiftIn = sh;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
    endtask

    task automatic run_op(input mb_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sh, input logic [DW-1:0] res, input logic c,
                          input logic z, input string nm);
        push(res, c, z, nm);
        start_op(op, a, b, sh, nm);
        wait_ready(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        check("rst_carry", 32'(CarryOut), 32'd0);
        check("rst_zero", 32'(ZeroOut), 32'd1);
        check("rst_aluop", 32'(AluOp), 32'(CLR));
        #1;
        Reset_n = 1'b1;
        tick();

        // ADD with carry across lanes; latency and Ready profile
        push(16'h0100, 1'b0, 1'b0, "add");
        start_op(MB_ADD, 16'h00FF, 16'h0001, 1'b0, "add");
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            check($sformatf("add_ready_c%0d", i), 32'(Ready), 32'd0);
            check($sformatf("add_done_c%0d", i), 32'(Done), (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("add_ready_after", 32'(Ready), 32'd1);

        // SUB
        run_op(MB_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0, "sub_nb");
        run_op(MB_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
        run_op(MB_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, "sub_zero");

        // Shifts
        run_op(MB_LSH, 16'h8001, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, "lsh");
        push(16'h00C0, 1'b0, 1'b0, "rsh");
        start_op(MB_RSH, 16'h0180, 16'hFFFF, 1'b0, "rsh");
        @(negedge Clk);
        check("rsh_alua_lane1", 32'(AluA), 32'h01);
        @(negedge Clk);
        check("rsh_alua_lane0", 32'(AluA), 32'h80);
        tick();
        wait_ready("rsh");

        run_op(MB_AND, 16'hF00F, 16'h3C3C, 1'b0, 16'h300C, 1'b0, 1'b0, "and");

        // Start during RUN and DONE is ignored
        push(16'h0003, 1'b1, 1'b0, "ign");
        start_op(MB_ADD, 16'hFFFF, 16'h0004, 1'b0, "ign");
        Op    = MB_XOR;
        OpA   = 16'h5555;
        OpB   = 16'hFFFF;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("ign_done_state", 32'(Done), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("ign_ready_back", 32'(Ready), 32'd1);
        repeat (3) tick();
        check("ign_result_hold", 32'(Result), 32'h0003);
        check("ign_still_idle", 32'(Ready), 32'd1);

        // Reset in the second RUN cycle
        start_op(MB_ADD, 16'h1111, 16'h1111, 1'b0, "rst_mid");
        tick();
        Reset_n = 1'b0;
        #1;
        check("rstmid_ready", 32'(Ready), 32'd1);
        check("rstmid_result", 32'(Result), 32'd0);
        check("rstmid_zero", 32'(ZeroOut), 32'd1);
        check("rstmid_carry", 32'(CarryOut), 32'd0);
        check("rstmid_done", 32'(Done), 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        repeat (3) tick();
        run_op(MB_XOR, 16'hF0F0, 16'hFFFF, 1'b0, 16'h0F0F, 1'b0, 1'b0, "xor");

`ifdef MB_ALU_SEQ_CMP_EN
        run_op(MB_OR, 16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 1'b0, 1'b0, "or_aaaa");
        run_op(MB_CMP, 16'h0005, 16'h0005, 1'b0, 16'hAAAA, 1'b1, 1'b1, "cmp_eq");
`else
        run_op(mb_op_t'(3'd7), 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b1, "illegal");
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
